// File: rtl/sc_mvm_engine.sv
// Stochastic-computing matrix-vector multiply: N bipolar activation streams
// scaled by one signed weight, accumulated in saturating up/down counters.
module sc_mvm_engine #(
   parameter int N  = 4,
   parameter int XW = 4,
   parameter int WW = 6,
   parameter int AW = 8
) (
   input  logic            i_clk_smvm,
   input  logic            i_rst_smvm,
   input  logic            i_start_smvm,
   input  logic            i_acc_mode,
   input  logic [N*XW-1:0] i_x_bn,
   input  logic [WW-1:0]   i_w_smvm,
   output logic            o_ready,
   output logic            o_busy,
   output logic            o_valid,
   output logic [N*AW-1:0] o_wx_result
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [XW-1:0] XOFF    = {1'b1, {(XW-1){1'b0}}};
   localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

   state_t                  state_q, state_d;
   logic [N*XW-1:0]         x_q, x_d;
   logic [WW-1:0]           len_q, len_d;
   logic [WW-1:0]           k_q, k_d;
   logic                    neg_q, neg_d;
   logic [N-1:0][AW-1:0]    acc_q, acc_d;
   logic [WW-1:0]           w_abs;
   logic [XW-1:0]           rev;
   logic [N-1:0]            up_s;

   function automatic logic [AW-1:0] sat_step(input logic [AW-1:0] a, input logic up);
      if (up) return (a == ACC_MAX) ? a : a + 1'b1;
      else    return (a == ACC_MIN) ? a : a - 1'b1;
   endfunction

   // |w| as unsigned WW bits, so the most negative weight maps to 2^(WW-1)
   assign w_abs = i_w_smvm[WW-1] ? (~i_w_smvm + 1'b1) : i_w_smvm;

   always_comb begin
      rev = '0;
      for (int unsigned i = 0; i < XW; i++) rev[i] = k_q[XW-1-i];
   end

   // Offset-binary activation compared against the bit-reversed counter
   always_comb begin
      up_s = '0;
      for (int unsigned c = 0; c < N; c++)
         up_s[c] = ((x_q[c*XW +: XW] ^ XOFF) > rev) ^ neg_q;
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      len_d   = len_q;
      k_d     = k_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE: begin
            if (i_start_smvm) begin
               x_d   = i_x_bn;
               len_d = w_abs;
               neg_d = i_w_smvm[WW-1];
               k_d   = '0;
               // Mode only matters at this edge, so it is consumed here rather than stored
               if (!i_acc_mode) acc_d = '0;
               state_d = (w_abs != '0) ? S_RUN : S_DONE;
            end
         end
         S_RUN: begin
            for (int unsigned c = 0; c < N; c++) acc_d[c] = sat_step(acc_q[c], up_s[c]);
            k_d = k_q + 1'b1;
            if (k_q == len_q - 1'b1) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_smvm) begin
      if (i_rst_smvm) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         len_q   <= '0;
         k_q     <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         len_q   <= len_d;
         k_q     <= k_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
      end
   end

   assign o_ready     = (state_q == S_IDLE);
   assign o_busy      = (state_q == S_RUN) || (state_q == S_DONE);
   assign o_valid     = (state_q == S_DONE);
   assign o_wx_result = acc_q;

endmodule

// File: tb/tb_sc_mvm_engine.sv
// Directed bench for sc_mvm_engine: vector table plus hand sequences for
// saturation, start-while-busy and reset-mid-run.
module tb_sc_mvm_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        acc_mode;
   logic [15:0] x_bn;
   logic [5:0]  w;
   logic        ready, busy, valid;
   logic [31:0] res;

   int errors = 0;
   int checks = 0;

   sc_mvm_engine #(.N(4), .XW(4), .WW(6), .AW(8)) dut (
      .i_clk_smvm  (clk),
      .i_rst_smvm  (rst),
      .i_start_smvm(start),
      .i_acc_mode  (acc_mode),
      .i_x_bn      (x_bn),
      .i_w_smvm    (w),
      .o_ready     (ready),
      .o_busy      (busy),
      .o_valid     (valid),
      .o_wx_result (res)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x;
      int          w;
      logic        mode;
      logic [31:0] exp_res;
      int          lat;
      string       name;
   } vec_t;

   function automatic logic [15:0] pack_x(input int a, input int b, input int c, input int d);
      return {d[3:0], c[3:0], b[3:0], a[3:0]};
   endfunction

   function automatic logic [31:0] pack_r(input int a, input int b, input int c, input int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_results(input string nm, input logic [31:0] exp_res);
      for (int c = 0; c < 4; c++)
         chk($sformatf("%s ch%0d", nm, c), int'($signed(res[c*8 +: 8])),
             int'($signed(exp_res[c*8 +: 8])));
   endtask

   // Called at #1 after an edge with the DUT idle; returns one cycle after o_valid.
   // glitch>0 raises start again for two cycles starting at that cycle count.
   task automatic do_op(input logic [15:0] xv, input int wv, input logic mode, input int lat,
                        input logic [31:0] exp_res, input int glitch, input string nm);
      int cnt;
      int seen;
      int bad;
      x_bn = xv; w = wv[5:0]; acc_mode = mode; start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 1; seen = -1; bad = 0;
      while (cnt <= 100) begin
         if (ready || !busy) bad = 1;
         if (valid) begin
            seen = cnt;
            break;
         end
         if (glitch > 0) begin
            start = (cnt >= glitch) && (cnt < glitch + 2);
            w = start ? 6'd16 : wv[5:0];
         end
         tick();
         cnt++;
      end
      start = 1'b0;
      w = wv[5:0];
      chk({nm, " valid latency"}, seen, lat);
      chk({nm, " ready/busy during op"}, bad, 0);
      chk_results(nm, exp_res);
      tick();
      chk({nm, " idle after done (valid,ready)"}, int'({valid, ready}), 1);
   endtask

   task automatic watch_no_valid(input int n, input string nm);
      int hits = 0;
      for (int i = 0; i < n; i++) begin
         if (valid || !ready) hits++;
         tick();
      end
      chk({nm, " no spurious activity"}, hits, 0);
   endtask

   vec_t tbl[8];
   int   ch0_exp[5] = '{32, 64, 96, 127, 127};
   int   ch1_exp[5] = '{-28, -56, -84, -112, -127};
   int   ch3_exp[5] = '{4, 8, 12, 16, 20};

   initial begin
      tbl[0] = '{pack_x(4, -8, 7, 0),  16, 1'b0, pack_r(8, -16, 14, 0),  17, "w16"};
      tbl[1] = '{pack_x(4, -8, 7, 0), -16, 1'b0, pack_r(-8, 16, -14, 0), 17, "w-16"};
      tbl[2] = '{pack_x(4, -8, 0, -1),  8, 1'b0, pack_r(4, -8, 0, 0),     9, "w8"};
      tbl[3] = '{pack_x(4, -8, 7, 0),   0, 1'b0, pack_r(0, 0, 0, 0),      1, "w0 clear"};
      tbl[4] = '{pack_x(4, -8, 7, 0),  16, 1'b0, pack_r(8, -16, 14, 0),  17, "w16 again"};
      tbl[5] = '{pack_x(7, 7, 7, 7),    0, 1'b1, pack_r(8, -16, 14, 0),   1, "w0 hold"};
      tbl[6] = '{pack_x(1, 2, -3, 3),   1, 1'b1, pack_r(9, -15, 15, 1),   2, "w1 acc"};
      tbl[7] = '{pack_x(-8, 7, 0, -1), -1, 1'b1, pack_r(10, -16, 14, 0),  2, "w-1 acc"};

      rst = 1'b1; start = 1'b0; acc_mode = 1'b0; x_bn = '0; w = '0;
      tick(); tick();
      rst = 1'b0;
      chk("reset ready", int'(ready), 1);
      chk("reset busy", int'(busy), 0);
      chk("reset valid", int'(valid), 0);
      chk("reset results", int'(res), 0);

      for (int i = 0; i < 8; i++)
         do_op(tbl[i].x, tbl[i].w, tbl[i].mode, tbl[i].lat, tbl[i].exp_res, 0, tbl[i].name);

      // Saturation: five accumulated runs with the most negative weight
      rst = 1'b1; tick(); rst = 1'b0;
      for (int r = 0; r < 5; r++)
         do_op(pack_x(-8, 7, 0, -1), -32, 1'b1, 33,
               pack_r(ch0_exp[r], ch1_exp[r], 0, ch3_exp[r]), 0, $sformatf("sat run%0d", r));

      // Start raised during RUN must be dropped, not queued
      do_op(pack_x(4, -8, 0, -1), 8, 1'b0, 9, pack_r(4, -8, 0, 0), 3, "start in run");
      watch_no_valid(20, "after start in run");

      // Reset mid-run abandons the stream
      x_bn = pack_x(4, -8, 7, 0); w = 6'd16; acc_mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrun reset results", int'(res), 0);
      chk("midrun reset ready", int'(ready), 1);
      chk("midrun reset valid/busy", int'({valid, busy}), 0);
      watch_no_valid(20, "after midrun reset");
      do_op(pack_x(4, -8, 7, 0), 16, 1'b0, 17, pack_r(8, -16, 14, 0), 0, "post reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
